serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Bit counter width: counts 0..WIDTH-1.
   function automatic int cnt_w(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, bo = borrow out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   // Difference and borrow of a single bit position.
   always_comb begin
      d  = x ^ y ^ bi;
      bo = (~x & y) | (~(x ^ y) & bi);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH cycles.
// Optional signed-overflow output enabled by SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   // Holds the WIDTH-1 difference bits already produced; the final bit
   // comes straight from the cell on the last RUN cycle.
   logic [WIDTH-2:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_borrow;

   logic             w_d;
   logic             w_bo;
   logic [WIDTH-1:0] w_res_nxt;

   full_subtractor u_fs (
      .x  (r_a_sh[0]),
      .y  (r_b_sh[0]),
      .bi (r_borrow),
      .d  (w_d),
      .bo (w_bo)
   );

   // New bit enters at the MSB; result register shifts right.
   always_comb begin
      w_res_nxt = {w_d, r_res};
   end

   // Control FSM plus datapath shift registers and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_a_sh    <= '0;
         r_b_sh    <= '0;
         r_res     <= '0;
         r_cnt     <= '0;
         r_borrow  <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         diff      <= '0;
         bout      <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a_sh   <= a;
                  r_b_sh   <= b;
                  r_borrow <= bin;
                  r_cnt    <= '0;
                  in_ready <= 1'b0;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_res    <= w_res_nxt[WIDTH-1:1];
               r_borrow <= w_bo;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  diff      <= w_res_nxt;
                  bout      <= w_bo;
                  out_valid <= 1'b1;
                  r_state   <= DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                  // Borrow into MSB vs borrow out of MSB.
                  ovf       <= r_borrow ^ w_bo;
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               r_state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (scoreboard of expected results).
`timescale 1ns/1ps
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         bin = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] diff;
   logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic         ovf;
`endif

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
     ,.ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
   } exp_t;
   exp_t sb[$];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic bi);
      exp_t       e;
      logic [W:0] r;
      int         sx, sy, s;
      r    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
      e.d  = r[W-1:0];
      e.bo = r[W];
      sx   = x[W-1] ? int'(x) - (1 << W) : int'(x);
      sy   = y[W-1] ? int'(y) - (1 << W) : int'(y);
      s    = sx - sy - int'(bi);
      e.ov = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
      return e;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present operands, wait (bounded) for in_ready, take the accept edge.
   task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic bi, output int acc);
      a = x; b = y; bin = bi; in_valid = 1'b1;
      for (int n = 0; n < 4*W && !in_ready; n++) tick;
      tick;
      acc = cyc;
      sb.push_back(model(x, y, bi));
      in_valid = 1'b0;
   endtask

   // Bounded wait for out_valid; optionally scramble operands meanwhile.
   task automatic wait_valid(input bit scramble);
      for (int n = 0; n < 4*W && !out_valid; n++) begin
         if (scramble) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
         end
         tick;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b1; a = 8'h12; b = 8'h34;
      tick; tick;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (diff !== '0) begin errors++; $display("FAIL reset_diff: got %h want 00", diff); end
      checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b want 0", bout); end
      in_valid = 1'b0;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_basic;
      logic [W-1:0] xs [8];
      logic [W-1:0] ys [8];
      logic         bs [8];
      int           acc;
      exp_t         e;
      xs[0] = 8'h05; ys[0] = 8'h03; bs[0] = 1'b0;
      xs[1] = 8'h03; ys[1] = 8'h05; bs[1] = 1'b0;
      xs[2] = 8'h00; ys[2] = 8'h00; bs[2] = 1'b1;
      xs[3] = 8'h80; ys[3] = 8'h01; bs[3] = 1'b0;
      xs[4] = 8'h00; ys[4] = 8'hFF; bs[4] = 1'b1;
      for (int i = 5; i < 8; i++) begin
         xs[i] = W'($urandom); ys[i] = W'($urandom); bs[i] = 1'($urandom);
      end
      for (int i = 0; i < 8; i++) begin
         accept(xs[i], ys[i], bs[i], acc);
         wait_valid(1'b0);
         checks++; if (cyc - acc != W) begin errors++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, cyc - acc, W); end
         e = sb.pop_front();
         checks++; if (diff !== e.d) begin errors++; $display("FAIL basic_diff[%0d]: got %h want %h", i, diff, e.d); end
         checks++; if (bout !== e.bo) begin errors++; $display("FAIL basic_bout[%0d]: got %b want %b", i, bout, e.bo); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         checks++; if (ovf !== e.ov) begin errors++; $display("FAIL basic_ovf[%0d]: got %b want %b", i, ovf, e.ov); end
`endif
         out_ready = 1'b1;
         tick;
         out_ready = 1'b0;
         checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_handoff[%0d]: out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_backpressure;
      int   acc;
      exp_t e;
      accept(8'h05, 8'h03, 1'b0, acc);
      for (int n = 0; n < 4*W && !out_valid; n++) begin
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_run_in_ready: got %b want 0", in_ready); end
         tick;
      end
      e = sb.pop_front();
      for (int k = 0; k < 5; k++) begin
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold_flags[%0d]: out_valid=%b in_ready=%b want 1/0", k, out_valid, in_ready);
         end
         checks++; if (diff !== e.d || bout !== e.bo) begin
            errors++; $display("FAIL bp_hold_data[%0d]: got %h/%b want %h/%b", k, diff, bout, e.d, e.bo);
         end
         tick;
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_handoff: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_run;
      int   acc;
      exp_t e;
      bit   seen;
      accept(8'h5A, 8'h21, 1'b1, acc);
      tick; tick; tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      sb.delete();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
      checks++; if (diff !== '0) begin errors++; $display("FAIL midrst_diff: got %h want 00", diff); end
      seen = 1'b0;
      for (int n = 0; n < W + 2; n++) begin
         if (out_valid) seen = 1'b1;
         tick;
      end
      checks++; if (seen) begin errors++; $display("FAIL midrst_abort: out_valid rose after aborted op"); end
      accept(8'hC3, 8'h3C, 1'b0, acc);
      wait_valid(1'b0);
      e = sb.pop_front();
      checks++; if (cyc - acc != W) begin errors++; $display("FAIL midrst_latency: got %0d want %0d", cyc - acc, W); end
      checks++; if (diff !== e.d || bout !== e.bo) begin
         errors++; $display("FAIL midrst_result: got %h/%b want %h/%b", diff, bout, e.d, e.bo);
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      int   acc1, acc2;
      exp_t e;
      out_ready = 1'b1;
      accept(8'h9C, 8'h4B, 1'b1, acc1);
      in_valid = 1'b1;
      wait_valid(1'b1);
      checks++; if (cyc - acc1 != W) begin errors++; $display("FAIL b2b_latency1: got %0d want %0d", cyc - acc1, W); end
      e = sb.pop_front();
      checks++; if (diff !== e.d || bout !== e.bo) begin
         errors++; $display("FAIL b2b_result1: got %h/%b want %h/%b", diff, bout, e.d, e.bo);
      end
      a = 8'h10; b = 8'h20; bin = 1'b1;
      tick;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_handoff: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
      tick;
      acc2 = cyc;
      sb.push_back(model(8'h10, 8'h20, 1'b1));
      checks++; if (acc2 - acc1 != W + 2) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", acc2 - acc1, W + 2); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept2: in_ready=%b want 0", in_ready); end
      in_valid = 1'b0;
      wait_valid(1'b1);
      checks++; if (cyc - acc2 != W) begin errors++; $display("FAIL b2b_latency2: got %0d want %0d", cyc - acc2, W); end
      e = sb.pop_front();
      checks++; if (diff !== e.d || bout !== e.bo) begin
         errors++; $display("FAIL b2b_result2: got %h/%b want %h/%b", diff, bout, e.d, e.bo);
      end
      tick;
      out_ready = 1'b0;
   endtask

   initial begin
      tick;
      test_reset;
      test_basic;
      test_backpressure;
      test_reset_mid_run;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
